prescaled_updown_counter: RTL and testbench

//   Parametrised modulo-N up/down counter with built-in clock-enable prescaler, for

---
 rtl/prescaled_updown_counter.sv | 95 +++++++++
 tb/tb_prescaled_updown_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_updown_counter.sv
// Modulo-N up/down counter stepped by a clock-enable prescaler tick.
// Supports parallel load with clamp, hold, wrap or saturate, and a terminal-count pulse.
module prescaled_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int DIV      = 50_000_000,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             Clear_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             tc
);

  localparam int               PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_TOP = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_VAL);

  generate
    if (DIV < 1 || MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_param
      $error("prescaled_updown_counter: illegal DIV/MAX_VAL/WIDTH combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  mode_e            mode;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  assign mode = mode_e'(sel);

  // Gated by Clear_n so the strobe stays low while reset holds pre at 0 (matters for DIV=1).
  assign tick = en & Clear_n & (pre_q == PRE_TOP);

  always_comb begin
    pre_d = pre_q;
    q_d   = q_q;
    tc_d  = 1'b0;
    if (mode == MODE_LOAD) begin
      // Load ignores en and tick, and restarts the prescaler phase.
      pre_d = '0;
      q_d   = (load_val > MAXV) ? MAXV : load_val;
    end else begin
      if (en) pre_d = (pre_q == PRE_TOP) ? '0 : pre_q + 1'b1;
      if (tick) begin
        case (mode)
          MODE_UP: begin
            if (q_q == MAXV) begin
              q_d  = SATURATE ? MAXV : '0;
              tc_d = 1'b1;
            end else begin
              q_d = q_q + 1'b1;
            end
          end
          MODE_DOWN: begin
            if (q_q == '0) begin
              q_d  = SATURATE ? '0 : MAXV;
              tc_d = 1'b1;
            end else begin
              q_d = q_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      pre_q <= '0;
      q_q   <= '0;
      tc_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      q_q   <= q_d;
      tc_q  <= tc_d;
    end
  end

  assign Q  = q_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench: A = decade wrap DIV=4, B = decade saturate DIV=4, C = 4-bit wrap DIV=1.
module tb_prescaled_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] load_val = 4'd0;

  logic [3:0] qa, qb, qc;
  logic       ticka, tickb, tickc, tca, tcb, tcc;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  always #5 clk = ~clk;

  prescaled_updown_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(4), .SATURATE(1'b0)) dut_a (
    .clk(clk), .Clear_n(rst_n), .en(en), .sel(sel), .load_val(load_val),
    .Q(qa), .tick(ticka), .tc(tca));

  prescaled_updown_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(4), .SATURATE(1'b1)) dut_b (
    .clk(clk), .Clear_n(rst_n), .en(en), .sel(sel), .load_val(load_val),
    .Q(qb), .tick(tickb), .tc(tcb));

  prescaled_updown_counter #(.WIDTH(4), .MAX_VAL(15), .DIV(1), .SATURATE(1'b0)) dut_c (
    .clk(clk), .Clear_n(rst_n), .en(en), .sel(sel), .load_val(load_val),
    .Q(qc), .tick(tickc), .tc(tcc));

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; sel = 2'b00; load_val = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({qa, tca, ticka, qb, tcb, tickb, qc, tcc, tickc} !== 18'd0) begin
      nmis++; $display("FAIL reset_state: got %h want 0", {qa, tca, ticka, qb, tcb, tickb, qc, tcc, tickc});
    end
    en = 1'b1;
    #1;
    nvec++;
    if (tickc !== 1'b0) begin nmis++; $display("FAIL reset_tick_gated: got %b want 0", tickc); end
    @(negedge clk);
    rst_n = 1'b1; sel = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      nvec++;
      if (ticka !== 1'(k % 4 == 3)) begin
        nmis++; $display("FAIL reset_tick_phase k=%0d: got %b want %b", k, ticka, (k % 4 == 3));
      end
      if (k == 4) begin
        nvec++;
        if (qa !== 4'd1) begin nmis++; $display("FAIL reset_first_step: got %0d want 1", qa); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({qa, tca, tickc} !== 6'd0) begin
      nmis++; $display("FAIL reset_async_midcount: got q=%0d tc=%b tickc=%b want 0", qa, tca, tickc);
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    apply_reset();
    sel = 2'b00; en = 1'b1;
    for (int t = 1; t <= 10; t++) sb_a.push_back('{q: 4'(t % 10), tc: 1'(t == 10)});
    for (int t = 1; t <= 10; t++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        nvec++;
        if (c < 4) begin
          if (tca !== 1'b0) begin nmis++; $display("FAIL up_tc_idle t=%0d: got %b want 0", t, tca); end
        end else begin
          e = sb_a.pop_front();
          if (qa !== e.q || tca !== e.tc) begin
            nmis++; $display("FAIL up_wrap t=%0d: got q=%0d tc=%b want q=%0d tc=%b", t, qa, tca, e.q, e.tc);
          end
        end
      end
    end
    @(negedge clk);
    nvec++;
    if (tca !== 1'b0) begin nmis++; $display("FAIL up_tc_width: got %b want 0", tca); end
  endtask

  task automatic test_down_sat();
    exp_t ea, eb;
    logic [3:0] qa_x [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       ta_x [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] qb_x [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic       tb_x [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    sel = 2'b10; load_val = 4'd2; en = 1'b1;
    @(negedge clk);
    nvec++;
    if (qa !== 4'd2 || qb !== 4'd2 || tca !== 1'b0 || tcb !== 1'b0) begin
      nmis++; $display("FAIL down_load2: got a=%0d b=%0d want 2", qa, qb);
    end
    sel = 2'b01;
    for (int t = 0; t < 4; t++) begin
      sb_a.push_back('{q: qa_x[t], tc: ta_x[t]});
      sb_b.push_back('{q: qb_x[t], tc: tb_x[t]});
    end
    for (int t = 0; t < 4; t++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        nvec++;
        if (c < 4) begin
          if (tca !== 1'b0 || tcb !== 1'b0) begin
            nmis++; $display("FAIL down_tc_idle t=%0d: got a=%b b=%b want 0", t, tca, tcb);
          end
        end else begin
          ea = sb_a.pop_front();
          eb = sb_b.pop_front();
          if (qa !== ea.q || tca !== ea.tc) begin
            nmis++; $display("FAIL down_wrap t=%0d: got q=%0d tc=%b want q=%0d tc=%b", t, qa, tca, ea.q, ea.tc);
          end
          nvec++;
          if (qb !== eb.q || tcb !== eb.tc) begin
            nmis++; $display("FAIL down_sat t=%0d: got q=%0d tc=%b want q=%0d tc=%b", t, qb, tcb, eb.q, eb.tc);
          end
        end
      end
    end
  endtask

  task automatic test_load_clamp();
    exp_t ea, eb;
    apply_reset();
    sel = 2'b00; en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0; sel = 2'b10; load_val = 4'd7;
    @(negedge clk);
    nvec++;
    if (qa !== 4'd7 || tca !== 1'b0 || ticka !== 1'b0) begin
      nmis++; $display("FAIL load7_en0: got q=%0d tc=%b tick=%b want 7,0,0", qa, tca, ticka);
    end
    load_val = 4'd15;
    @(negedge clk);
    nvec++;
    if (qa !== 4'd9 || qb !== 4'd9 || tca !== 1'b0) begin
      nmis++; $display("FAIL load_clamp: got a=%0d b=%0d tc=%b want 9,9,0", qa, qb, tca);
    end
    sel = 2'b00; en = 1'b1;
    sb_a.push_back('{q: 4'd0, tc: 1'b1});
    sb_b.push_back('{q: 4'd9, tc: 1'b1});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      nvec++;
      if (c < 4) begin
        if (ticka !== 1'(c == 3)) begin
          nmis++; $display("FAIL load_pre_cleared c=%0d: got %b want %b", c, ticka, (c == 3));
        end
      end else begin
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        if (qa !== ea.q || tca !== ea.tc || qb !== eb.q || tcb !== eb.tc) begin
          nmis++; $display("FAIL load_then_up: got a=%0d/%b b=%0d/%b want %0d/%b %0d/%b",
                           qa, tca, qb, tcb, ea.q, ea.tc, eb.q, eb.tc);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    exp_t e;
    int ticks;
    apply_reset();
    sel = 2'b00; en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nvec++;
      if (qa !== 4'd1 || ticka !== 1'b0 || tca !== 1'b0) begin
        nmis++; $display("FAIL en_freeze c=%0d: got q=%0d tick=%b tc=%b want 1,0,0", c, qa, ticka, tca);
      end
    end
    en = 1'b1;
    sb_a.push_back('{q: 4'd2, tc: 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      nvec++;
      if (c < 3) begin
        if (ticka !== 1'(c == 2)) begin
          nmis++; $display("FAIL en_resume_phase c=%0d: got %b want %b", c, ticka, (c == 2));
        end
      end else begin
        e = sb_a.pop_front();
        if (qa !== e.q || tca !== e.tc) begin
          nmis++; $display("FAIL en_resume_step: got q=%0d tc=%b want q=%0d tc=%b", qa, tca, e.q, e.tc);
        end
      end
    end
    sel = 2'b11;
    ticks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ticks += int'(ticka);
      nvec++;
      if (qa !== 4'd2 || tca !== 1'b0) begin
        nmis++; $display("FAIL hold_const c=%0d: got q=%0d tc=%b want 2,0", c, qa, tca);
      end
    end
    nvec++;
    if (ticks != 2) begin nmis++; $display("FAIL hold_ticks: got %0d want 2", ticks); end
  endtask

  task automatic test_mode_switch();
    exp_t e;
    apply_reset();
    sel = 2'b00; en = 1'b1;
    repeat (6) @(negedge clk);
    sel = 2'b01;
    sb_a.push_back('{q: 4'd0, tc: 1'b0});
    repeat (2) @(negedge clk);
    e = sb_a.pop_front();
    nvec++;
    if (qa !== e.q || tca !== e.tc) begin
      nmis++; $display("FAIL mode_switch: got q=%0d tc=%b want q=%0d tc=%b", qa, tca, e.q, e.tc);
    end
  endtask

  task automatic test_div1();
    exp_t e;
    apply_reset();
    sel = 2'b10; load_val = 4'd14; en = 1'b1;
    @(negedge clk);
    nvec++;
    if (qc !== 4'd14 || tcc !== 1'b0) begin
      nmis++; $display("FAIL div1_load: got q=%0d tc=%b want 14,0", qc, tcc);
    end
    sel = 2'b00;
    sb_c.push_back('{q: 4'd15, tc: 1'b0});
    sb_c.push_back('{q: 4'd0,  tc: 1'b1});
    sb_c.push_back('{q: 4'd1,  tc: 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = sb_c.pop_front();
      nvec++;
      if (qc !== e.q || tcc !== e.tc || tickc !== 1'b1) begin
        nmis++; $display("FAIL div1_up c=%0d: got q=%0d tc=%b tick=%b want q=%0d tc=%b tick=1",
                         c, qc, tcc, tickc, e.q, e.tc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_clamp();
    test_enable_hold();
    test_mode_switch();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
